// File: rtl/tl_sram_port_pkg.sv
// tl_sram_port shared definitions.
// Opcodes, response codes and FSM encoding.
package tl_sram_port_pkg;

  localparam logic [2:0] TL_OP_PUTFULL = 3'd0;
  localparam logic [2:0] TL_OP_PUTPART = 3'd1;
  localparam logic [2:0] TL_OP_GET     = 3'd4;

  localparam logic [2:0] TL_D_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACKDATA  = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DENY  = 3'd4
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == TL_OP_PUTFULL) ||
           (op == TL_OP_PUTPART) ||
           (op == TL_OP_GET);
  endfunction

endpackage

// File: rtl/tl_sram_port_if.sv
// TileLink-UL A/D channel pair.
// master drives A and d_ready; slave drives D and a_ready.
interface tl_sram_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SRC_W  = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [3:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [DATA_W/8-1:0] a_mask;
  logic [DATA_W-1:0] a_data;
  logic              a_corrupt;
  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [3:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic              d_corrupt;
  logic [DATA_W-1:0] d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_source,
    output a_address, a_mask, a_data, a_corrupt,
    output d_ready,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source,
    input  d_denied, d_corrupt, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source,
    input  a_address, a_mask, a_data, a_corrupt,
    input  d_ready,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source,
    output d_denied, d_corrupt, d_data
  );
endinterface

// File: rtl/tl_resp_fifo.sv
// 2-entry response buffer for read beats.
// Entry = {corrupt, data}.
module tl_resp_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok, push_ok;

  // Pointer/count update; push into a full FIFO only with a pop.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    pop_ok  = pop && (cnt_q != 2'd0);
    push_ok = push && ((cnt_q != 2'd2) || pop_ok);
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (pop_ok) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/tl_sram_port.sv
// TileLink-UL slave onto a single-port sync SRAM.
// Bursts, byte masks, denial, 2-deep read buffer.
module tl_sram_port
  import tl_sram_port_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int SRAM_AW      = 10,
  parameter int SRC_W        = 5,
  parameter int MAX_BEATS_LG = 3
) (
  input  logic                clk,
  input  logic                rst,
  tl_sram_port_if.slave       tl,
  output logic                sram_en,
  output logic                sram_we,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [DATA_W/8-1:0] sram_wmask,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int LG_B = $clog2(DATA_W / 8);
  localparam int BW   = MAX_BEATS_LG + 1;
  localparam int MB   = DATA_W / 8;

  state_e             state_q, state_d;
  logic [BW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      iss_q, iss_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [2:0]         op_q, op_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [3:0]         size_q, size_d;
  logic               get_q, get_d;
  logic               infl_q, infl_d;
  logic               act_q, act_d;

  logic [3:0]         ex;
  logic               size_ok, aligned, op_ok;
  logic               is_get, legal;
  logic [BW-1:0]      beats;
  logic [ADDR_W-1:0]  low_m;
  logic [SRAM_AW-1:0] base;
  logic [2:0]         mask_op;
  logic [MB-1:0]      wmask;

  logic               pop;
  logic [1:0]         f_cnt;
  logic               f_full, f_empty;
  logic [DATA_W:0]    f_head;
  logic [2:0]         f_use;
  logic [2:0]         f_lim;

  tl_resp_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_q),
    .din   ({1'b0, sram_rdata}),
    .pop   (pop),
    .dout  (f_head),
    .count (f_cnt),
    .full  (f_full),
    .empty (f_empty)
  );

  // Request decode: beat count, legality, word address, write mask.
  always_comb begin
    ex = '0;
    if (tl.a_size > 4'(LG_B)) begin
      ex = tl.a_size - 4'(LG_B);
    end
    size_ok = (ex <= 4'(MAX_BEATS_LG));
    beats   = size_ok ? (BW'(1) << ex) : BW'(1);
    low_m   = ~({ADDR_W{1'b1}} << tl.a_size);
    aligned = ((tl.a_address & low_m) == '0);
    op_ok   = op_legal(tl.a_opcode);
    is_get  = (tl.a_opcode == TL_OP_GET);
    legal   = op_ok && size_ok && aligned;
    base    = tl.a_address[LG_B +: SRAM_AW];
    mask_op = (state_q == ST_IDLE) ? tl.a_opcode : op_q;
    wmask   = (mask_op == TL_OP_PUTPART) ? tl.a_mask : '1;
    if (tl.a_corrupt) begin
      wmask = '0;
    end
  end

  // FSM next state and all bus/SRAM outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    iss_d         = iss_q;
    addr_d        = addr_q;
    op_d          = op_q;
    src_d         = src_q;
    size_d        = size_q;
    get_d         = get_q;
    infl_d        = 1'b0;
    act_d         = 1'b1;
    pop           = 1'b0;
    f_use         = {1'b0, f_cnt} + {2'b0, infl_q};
    f_lim         = 3'd2;
    tl.a_ready    = 1'b0;
    tl.d_valid    = 1'b0;
    tl.d_opcode   = TL_D_ACK;
    tl.d_denied   = 1'b0;
    tl.d_corrupt  = 1'b0;
    tl.d_data     = '0;
    tl.d_source   = src_q;
    tl.d_size     = size_q;
    sram_en       = 1'b0;
    sram_we       = 1'b0;
    sram_addr     = addr_q;
    sram_wmask    = '0;
    sram_wdata    = '0;

    unique case (state_q)
      ST_IDLE: begin
        tl.a_ready = act_q;
        if (tl.a_valid && act_q) begin
          src_d  = tl.a_source;
          size_d = tl.a_size;
          op_d   = tl.a_opcode;
          get_d  = is_get;
          if (!legal) begin
            state_d = ST_DENY;
            if (is_get) begin
              cnt_d = beats;
            end else if (op_ok && size_ok) begin
              cnt_d = beats - 1'b1;
            end else begin
              cnt_d = '0;
            end
          end else if (is_get) begin
            state_d = ST_READ;
            cnt_d   = beats;
            iss_d   = beats;
            addr_d  = base;
          end else begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = base;
            sram_wmask = wmask;
            sram_wdata = tl.a_data;
            addr_d     = base + 1'b1;
            cnt_d      = beats - 1'b1;
            state_d    = (beats == BW'(1)) ? ST_ACK : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        tl.a_ready = 1'b1;
        if (tl.a_valid) begin
          sram_en    = 1'b1;
          sram_we    = 1'b1;
          sram_wmask = wmask;
          sram_wdata = tl.a_data;
          addr_d     = addr_q + 1'b1;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == BW'(1)) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        tl.d_valid = 1'b1;
        if (tl.d_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        tl.d_valid   = !f_empty;
        tl.d_opcode  = TL_D_ACKDATA;
        tl.d_corrupt = !f_empty && f_head[DATA_W];
        tl.d_data    = f_empty ? '0 : f_head[DATA_W-1:0];
        pop          = !f_empty && tl.d_ready;
        f_lim        = 3'd2 + {2'b0, pop};
        if (pop) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == BW'(1)) begin
            state_d = ST_IDLE;
          end
        end
        // Slot budget counts the read in flight and frees on pop.
        if ((iss_q != '0) && (f_use < f_lim) &&
            !(f_full && !pop)) begin
          sram_en = 1'b1;
          infl_d  = 1'b1;
          iss_d   = iss_q - 1'b1;
          addr_d  = addr_q + 1'b1;
        end
      end
      ST_DENY: begin
        if (!get_q) begin
          if (cnt_q != '0) begin
            tl.a_ready = 1'b1;
            if (tl.a_valid) begin
              cnt_d = cnt_q - 1'b1;
            end
          end else begin
            tl.d_valid  = 1'b1;
            tl.d_denied = 1'b1;
            if (tl.d_ready) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          tl.d_valid   = 1'b1;
          tl.d_opcode  = TL_D_ACKDATA;
          tl.d_denied  = 1'b1;
          tl.d_corrupt = 1'b1;
          if (tl.d_ready) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == BW'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset silences everything immediately.
    if (rst) begin
      pop          = 1'b0;
      infl_d       = 1'b0;
      tl.a_ready   = 1'b0;
      tl.d_valid   = 1'b0;
      tl.d_opcode  = TL_D_ACK;
      tl.d_denied  = 1'b0;
      tl.d_corrupt = 1'b0;
      tl.d_data    = '0;
      tl.d_source  = '0;
      tl.d_size    = '0;
      sram_en      = 1'b0;
      sram_we      = 1'b0;
      sram_addr    = '0;
      sram_wmask   = '0;
      sram_wdata   = '0;
    end
  end

  // State registers; act_q holds a_ready low one cycle past reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      iss_q   <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      src_q   <= '0;
      size_q  <= '0;
      get_q   <= 1'b0;
      infl_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      src_q   <= src_d;
      size_q  <= size_d;
      get_q   <= get_d;
      infl_q  <= infl_d;
      act_q   <= act_d;
    end
  end

endmodule

// File: tb/tb_tl_sram_port.sv
// Self-checking bench for tl_sram_port.
// Table of single-beat requests plus burst/reset sequences.
module tb_tl_sram_port;
  import tl_sram_port_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SAW = 10;
  localparam int SW  = 5;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corr;
    logic [4:0]  src;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_cor;
    logic [31:0] e_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tl_sram_port_if #(.DATA_W(DW), .ADDR_W(AW), .SRC_W(SW)) tl ();

  logic           sram_en, sram_we;
  logic [SAW-1:0] sram_addr;
  logic [3:0]     sram_wmask;
  logic [31:0]    sram_wdata;
  logic [31:0]    sram_rdata;
  logic [31:0]    mem [1024];

  tl_sram_port #(
    .DATA_W(DW), .ADDR_W(AW), .SRAM_AW(SAW),
    .SRC_W(SW), .MAX_BEATS_LG(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tl         (tl),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // SRAM model: byte-masked write, one-cycle read.
  always @(posedge clk) begin
    if (sram_en && sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end else if (sram_en) begin
      sram_rdata <= mem[sram_addr];
    end
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", nm, got, exp);
  endtask

  task automatic expire(input string nm);
    tot_cnt++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic vec_t mk(
    input logic [2:0] op, input logic [3:0] sz, input logic [31:0] ad,
    input logic [3:0] mk_, input logic [31:0] dt, input logic co,
    input logic [4:0] src, input logic [2:0] eop, input logic eden,
    input logic ecor, input logic [31:0] edat);
    vec_t v;
    v.op = op; v.size = sz; v.addr = ad; v.mask = mk_; v.data = dt;
    v.corr = co; v.src = src; v.e_op = eop; v.e_den = eden;
    v.e_cor = ecor; v.e_data = edat;
    return v;
  endfunction

  task automatic drive_a(input logic [2:0] op, input logic [3:0] sz,
                         input logic [31:0] ad, input logic [3:0] mk_,
                         input logic [31:0] dt, input logic co,
                         input logic [4:0] src);
    tl.a_opcode = op; tl.a_size = sz; tl.a_address = ad;
    tl.a_mask = mk_; tl.a_data = dt; tl.a_corrupt = co;
    tl.a_source = src; tl.a_valid = 1'b1;
  endtask

  // Hold a_valid until accepted, then drop it after the edge.
  task automatic accept(input string nm);
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tl.a_ready) begin ok = 1; break; end
    end
    if (!ok) expire(nm);
    @(posedge clk); #1;
    tl.a_valid = 1'b0;
  endtask

  task automatic run_single(input string nm, input vec_t v);
    bit ok = 0;
    @(posedge clk); #1;
    drive_a(v.op, v.size, v.addr, v.mask, v.data, v.corr, v.src);
    accept(nm);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tl.d_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      expire(nm);
      return;
    end
    check({nm, " d_opcode"}, tl.d_opcode, v.e_op);
    check({nm, " d_denied"}, tl.d_denied, v.e_den);
    check({nm, " d_corrupt"}, tl.d_corrupt, v.e_cor);
    check({nm, " d_data"}, tl.d_data, v.e_data);
    check({nm, " d_source"}, tl.d_source, v.src);
    check({nm, " d_size"}, tl.d_size, v.size);
    @(negedge clk);
    check({nm, " single beat"}, tl.d_valid, 1'b0);
  endtask

  task automatic put_beat(input string nm, input logic [2:0] op,
                          input logic [3:0] sz, input logic [31:0] ad,
                          input logic [3:0] mk_, input logic [31:0] dt,
                          input logic [4:0] src, input logic [9:0] ea,
                          input logic [3:0] em);
    @(posedge clk); #1;
    drive_a(op, sz, ad, mk_, dt, 1'b0, src);
    @(negedge clk);
    check({nm, " a_ready"}, tl.a_ready, 1'b1);
    check({nm, " en/we"}, {sram_en, sram_we}, 2'b11);
    check({nm, " addr"}, sram_addr, ea);
    check({nm, " wmask"}, sram_wmask, em);
  endtask

  task automatic expect_ack(input string nm, input logic [4:0] src,
                            input logic [3:0] sz);
    @(posedge clk); #1;
    tl.a_valid = 1'b0;
    @(negedge clk);
    check({nm, " ack valid"}, tl.d_valid, 1'b1);
    check({nm, " ack op"}, tl.d_opcode, TL_D_ACK);
    check({nm, " ack denied"}, tl.d_denied, 1'b0);
    check({nm, " ack source"}, tl.d_source, src);
    check({nm, " ack size"}, tl.d_size, sz);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vt [12];

  initial begin : main
    int issued, got, max_out, beats_seen;
    bit hold, en_seen;
    logic [31:0] hd;

    rst = 1'b1;
    tl.a_valid = 1'b0; tl.a_opcode = '0; tl.a_size = '0;
    tl.a_source = '0; tl.a_address = '0; tl.a_mask = '0;
    tl.a_data = '0; tl.a_corrupt = 1'b0; tl.d_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] <= '0;

    vt[0]  = mk(TL_OP_PUTFULL, 2, 32'h80, 4'h0, 32'hCAFEF00D, 0, 3,
                TL_D_ACK, 0, 0, 32'h0);
    vt[1]  = mk(TL_OP_GET, 2, 32'h80, 4'h0, 32'h0, 0, 4,
                TL_D_ACKDATA, 0, 0, 32'hCAFEF00D);
    vt[2]  = mk(TL_OP_PUTPART, 2, 32'h80, 4'h5, 32'h11223344, 0, 5,
                TL_D_ACK, 0, 0, 32'h0);
    vt[3]  = mk(TL_OP_GET, 2, 32'h80, 4'h0, 32'h0, 0, 6,
                TL_D_ACKDATA, 0, 0, 32'hCA22F044);
    vt[4]  = mk(TL_OP_PUTFULL, 2, 32'h80, 4'h0, 32'h0, 1, 7,
                TL_D_ACK, 0, 0, 32'h0);
    vt[5]  = mk(TL_OP_GET, 1, 32'h82, 4'h0, 32'h0, 0, 8,
                TL_D_ACKDATA, 0, 0, 32'hCA22F044);
    vt[6]  = mk(3'd2, 2, 32'h80, 4'h0, 32'h0, 0, 9,
                TL_D_ACK, 1, 0, 32'h0);
    vt[7]  = mk(TL_OP_GET, 2, 32'h81, 4'h0, 32'h0, 0, 10,
                TL_D_ACKDATA, 1, 1, 32'h0);
    vt[8]  = mk(TL_OP_PUTFULL, 2, 32'h83, 4'h0, 32'hFFFFFFFF, 0, 11,
                TL_D_ACK, 1, 0, 32'h0);
    vt[9]  = mk(TL_OP_GET, 0, 32'h80, 4'h0, 32'h0, 0, 12,
                TL_D_ACKDATA, 0, 0, 32'hCA22F044);
    vt[10] = mk(TL_OP_GET, 15, 32'h0, 4'h0, 32'h0, 0, 13,
                TL_D_ACKDATA, 1, 1, 32'h0);
    vt[11] = mk(TL_OP_PUTFULL, 15, 32'h0, 4'h0, 32'h0, 0, 14,
                TL_D_ACK, 1, 0, 32'h0);

    // Reset: quiet during and one cycle after.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst a_ready", tl.a_ready, 1'b0);
    check("rst d_valid", tl.d_valid, 1'b0);
    check("rst sram_en", sram_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst a_ready", tl.a_ready, 1'b0);
    check("post-rst d_valid", tl.d_valid, 1'b0);
    @(negedge clk);
    check("ready after rst", tl.a_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run_single($sformatf("vec%0d", i), vt[i]);
    end

    // Single Get latency.
    @(posedge clk); #1;
    mem[16] <= 32'hDEADBEEF;
    @(posedge clk); #1;
    drive_a(TL_OP_GET, 2, 32'h40, 4'h0, 32'h0, 1'b0, 5'h15);
    @(negedge clk);
    check("get1 accept", tl.a_ready, 1'b1);
    @(posedge clk); #1;
    tl.a_valid = 1'b0;
    @(negedge clk);
    check("get1 T+1 en/we", {sram_en, sram_we}, 2'b10);
    check("get1 T+1 addr", sram_addr, 10'h10);
    @(negedge clk);
    check("get1 T+2 d_valid", tl.d_valid, 1'b0);
    @(negedge clk);
    check("get1 T+3 d_valid", tl.d_valid, 1'b1);
    check("get1 opcode", tl.d_opcode, TL_D_ACKDATA);
    check("get1 data", tl.d_data, 32'hDEADBEEF);
    check("get1 source", tl.d_source, 5'h15);

    // 4-beat PutPartial, narrow mask on beat index 2.
    @(posedge clk); #1;
    mem[10'h42] <= 32'hAAAAAAAA;
    for (int i = 0; i < 4; i++) begin
      put_beat($sformatf("pp beat%0d", i), TL_OP_PUTPART, 4, 32'h100,
               (i == 2) ? 4'h3 : 4'hF, 32'h11111111 * (i + 1), 5'd7,
               10'(10'h40 + i), (i == 2) ? 4'h3 : 4'hF);
    end
    expect_ack("pp", 5'd7, 4'd4);
    @(posedge clk); #1;
    check("pp mem[0x42]", mem[10'h42], 32'hAAAA3333);
    check("pp mem[0x43]", mem[10'h43], 32'h44444444);

    // 8-beat Get with d_ready pattern 1,0,0,1.
    for (int i = 0; i < 8; i++) mem[10'h80 + i] <= 32'hB0000000 + i;
    @(posedge clk); #1;
    drive_a(TL_OP_GET, 5, 32'h200, 4'h0, 32'h0, 1'b0, 5'd9);
    accept("burst accept");
    issued = 0; got = 0; max_out = 0; hold = 0; hd = '0;
    for (int c = 0; c < 100 && got < 8; c++) begin
      tl.d_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      if (hold) begin
        check("burst stall hold", {tl.d_valid, tl.d_data}, {1'b1, hd});
        hold = 0;
      end
      if (sram_en && !sram_we) begin
        check($sformatf("burst rd addr%0d", issued), sram_addr,
              10'(10'h80 + issued));
        issued++;
      end
      if (tl.d_valid && tl.d_ready) begin
        check($sformatf("burst data%0d", got), tl.d_data,
              32'hB0000000 + got);
        got++;
      end else if (tl.d_valid) begin
        hold = 1;
        hd = tl.d_data;
      end
      if (issued - got > max_out) max_out = issued - got;
      @(posedge clk); #1;
    end
    tl.d_ready = 1'b1;
    check("burst beats", got, 8);
    check("burst reads", issued, 8);
    check("burst outstanding<=2", max_out <= 2, 1'b1);
    @(negedge clk);
    check("burst no extra", tl.d_valid, 1'b0);

    // Misaligned Get: denied, no SRAM access, 2 beats.
    @(posedge clk); #1;
    drive_a(TL_OP_GET, 3, 32'h4, 4'h0, 32'h0, 1'b0, 5'd2);
    accept("mis accept");
    beats_seen = 0; en_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (sram_en) en_seen = 1;
      if (tl.d_valid) begin
        check("mis d_op/den/cor",
              {tl.d_opcode, tl.d_denied, tl.d_corrupt},
              {TL_D_ACKDATA, 2'b11});
        check("mis d_data", tl.d_data, 32'h0);
        beats_seen++;
      end
    end
    check("mis beats", beats_seen, 2);
    check("mis no sram", en_seen, 1'b0);

    // Top-of-SRAM words, then address truncation to word 0.
    put_beat("top b0", TL_OP_PUTFULL, 3, 32'h1FF8, 4'h0, 32'h5, 5'd1,
             10'h3FE, 4'hF);
    put_beat("top b1", TL_OP_PUTFULL, 3, 32'h1FF8, 4'h0, 32'h6, 5'd1,
             10'h3FF, 4'hF);
    expect_ack("top", 5'd1, 4'd3);
    put_beat("wrap", TL_OP_PUTFULL, 2, 32'h2000, 4'h0, 32'h7, 5'd1,
             10'h000, 4'hF);
    expect_ack("wrap", 5'd1, 4'd2);

    // Reset in the middle of an 8-beat Get.
    @(posedge clk); #1;
    drive_a(TL_OP_GET, 5, 32'h200, 4'h0, 32'h0, 1'b0, 5'd3);
    accept("rstget accept");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst d_valid", tl.d_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("after rst d_valid", tl.d_valid, 1'b0);
    check("after rst sram_en", sram_en, 1'b0);
    @(negedge clk);
    check("after rst idle", {tl.a_ready, tl.d_valid, sram_en}, 3'b100);
    run_single("post-rst get",
               mk(TL_OP_GET, 2, 32'h40, 4'h0, 32'h0, 0, 5'd17,
                  TL_D_ACKDATA, 0, 0, 32'hDEADBEEF));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
